// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: pipeline-register/map-ROM side to sequencer bus; master drives op/cond/targets, slave returns ROM address and stack status
interface micro_sequencer_if #(
  parameter int ADDR_W = 11,
  parameter int COND_N = 8
);
  logic [2:0]                op;
  logic [$clog2(COND_N)-1:0] cond_sel;
  logic                      cond_pol;
  logic [COND_N-1:0]         cond_in;
  logic [ADDR_W-1:0]         branch_addr;
  logic [ADDR_W-1:0]         map_addr;
  logic [ADDR_W-1:0]         addr;
  logic                      stack_full;
  logic                      stack_empty;
  logic                      stack_err;
  modport master (
    output op, cond_sel, cond_pol, cond_in, branch_addr, map_addr,
    input  addr, stack_full, stack_empty, stack_err
  );
  modport slave (
    input  op, cond_sel, cond_pol, cond_in, branch_addr, map_addr,
    output addr, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: microcode next-address generator with return stack, conditional ops, wait and optional loop counter (USEQ_LOOP_COUNTER_EN)
//   i_clk, i_rst (sync, active-high); io_bus (slave): op, cond_sel, cond_pol, cond_in, branch_addr,
//   map_addr in; addr (combinational), stack_full, stack_empty, stack_err (registered decodes) out
module micro_sequencer #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  parameter int COND_N      = 8,
  parameter int CNT_W       = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  micro_sequencer_if.slave io_bus
);
  localparam logic [2:0] JUMP = 3'd1, JMAP = 3'd2, CALL = 3'd3, RET = 3'd4, WAIT = 3'd7;
  localparam int SEL_W = $clog2(COND_N);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [ADDR_W-1:0]     r_upc;
  logic [ADDR_W-1:0]     r_stack [1 << IDX_W];
  logic [SP_W-1:0]       r_sp;
  logic                  r_err;
  logic [(1<<SEL_W)-1:0] w_cin;
  logic                  w_cond, w_full, w_empty, w_call, w_ret, w_rpt, w_hold;
  logic [ADDR_W-1:0]     w_top, w_addr;
  // out-of-range selects land on the zero padding
  always_comb begin
    w_cin = '0;
    w_cin[COND_N-1:0] = io_bus.cond_in;
  end
  assign w_cond  = w_cin[io_bus.cond_sel] ^ io_bus.cond_pol;
  assign w_full  = r_sp == SP_W'(STACK_DEPTH);
  assign w_empty = r_sp == '0;
  assign w_call  = io_bus.op == CALL && w_cond;
  assign w_ret   = io_bus.op == RET && w_cond;
  assign w_hold  = io_bus.op == WAIT && !w_cond;
  assign w_top   = r_stack[IDX_W'(r_sp - SP_W'(1))];
`ifdef USEQ_LOOP_COUNTER_EN
  localparam logic [2:0] LDCT = 3'd5, RPCT = 3'd6;
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    if (i_rst) r_cnt <= '0;
    else if (io_bus.op == LDCT) r_cnt <= io_bus.branch_addr[CNT_W-1:0];
    else if (w_rpt) r_cnt <= r_cnt - CNT_W'(1);
  assign w_rpt = io_bus.op == RPCT && r_cnt != '0;
`else
  assign w_rpt = 1'b0;
`endif
  // a waiting word re-addresses itself: upc already points one past it
  assign w_addr = i_rst ? '0 :
                  (io_bus.op == JUMP && w_cond) || w_call || w_rpt ? io_bus.branch_addr :
                  io_bus.op == JMAP ? io_bus.map_addr :
                  w_ret && !w_empty ? w_top :
                  w_hold ? r_upc - ADDR_W'(1) : r_upc;
  assign io_bus.addr        = w_addr;
  assign io_bus.stack_full  = w_full;
  assign io_bus.stack_empty = w_empty;
  assign io_bus.stack_err   = r_err;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_upc <= ADDR_W'(1);
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      if (!w_hold) r_upc <= w_addr + ADDR_W'(1);
      if (w_call && !w_full) begin
        r_stack[IDX_W'(r_sp)] <= r_upc;
        r_sp <= r_sp + SP_W'(1);
      end
      if (w_ret && !w_empty) r_sp <= r_sp - SP_W'(1);
      if ((w_call && w_full) || (w_ret && w_empty)) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: randomized and directed checks of micro_sequencer against a queue-based next-address model
module tb_micro_sequencer;
  localparam int AW = 11, DEPTH = 4, CN = 8, CW = 8;
  localparam int AMOD = 1 << AW;
  localparam int CONT = 0, JUMP = 1, JMAP = 2, CALL = 3, RET = 4, LDCT = 5, RPCT = 6, WAIT = 7;
`ifdef USEQ_LOOP_COUNTER_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   checks = 0, failures = 0;
  int   m_upc = 1, m_cnt = 0;
  int   m_stk[$];
  bit   m_err = 1'b0;
  micro_sequencer_if #(.ADDR_W(AW), .COND_N(CN)) bus ();
  micro_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .COND_N(CN), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .io_bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic bit m_cond();
    return bit'((int'(bus.cond_in) >> int'(bus.cond_sel)) & 1) ^ bus.cond_pol;
  endfunction
  function automatic int m_addr();
    bit c = m_cond();
    int br = int'(bus.branch_addr);
    if (rst) return 0;
    case (int'(bus.op))
      JUMP, CALL: return c ? br : m_upc;
      JMAP:       return int'(bus.map_addr);
      RET:        return (c && m_stk.size() > 0) ? m_stk[$] : m_upc;
      RPCT:       return (EN && m_cnt != 0) ? br : m_upc;
      WAIT:       return c ? m_upc : (m_upc + AMOD - 1) % AMOD;
      default:    return m_upc;
    endcase
  endfunction
  task automatic m_tick();
    bit c = m_cond();
    int a = m_addr();
    if (rst) begin
      m_upc = 1; m_stk.delete(); m_err = 1'b0; m_cnt = 0;
      return;
    end
    case (int'(bus.op))
      CALL: if (c) begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else m_stk.push_back(m_upc);
      end
      RET: if (c) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else void'(m_stk.pop_back());
      end
      LDCT: if (EN) m_cnt = int'(bus.branch_addr) % (1 << CW);
      RPCT: if (EN && m_cnt != 0) m_cnt--;
      default: ;
    endcase
    if (!(int'(bus.op) == WAIT && !c)) m_upc = (a + 1) % AMOD;
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("addr", int'(bus.addr), m_addr());
    chk("stack_full", int'(bus.stack_full), int'(m_stk.size() == DEPTH));
    chk("stack_empty", int'(bus.stack_empty), int'(m_stk.size() == 0));
    chk("stack_err", int'(bus.stack_err), int'(m_err));
  end
  // lit < 0: no literal expectation for this cycle
  task automatic step(input int op, input int sel, input bit pol, input int cin,
                      input int br, input int map, input int lit);
    bus.op = 3'(op); bus.cond_sel = 3'(sel); bus.cond_pol = pol;
    bus.cond_in = 8'(cin); bus.branch_addr = 11'(br); bus.map_addr = 11'(map);
    @(negedge clk);
    if (lit >= 0) chk($sformatf("lit_addr_op%0d", op), int'(bus.addr), lit);
    @(posedge clk);
    m_tick();
    #1;
  endtask
  initial begin
    rst = 1'b1;
    step(CONT, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_empty", int'(bus.stack_empty), 1);
    chk("rst_err", int'(bus.stack_err), 0);
    step(CONT, 0, 0, 0, 0, 0, 1);
    step(CONT, 0, 0, 0, 0, 0, 2);
    step(CONT, 0, 0, 0, 0, 0, 3);
    step(JUMP, 0, 0, 1, 'h00F, 0, 'h00F);
    step(JUMP, 2, 0, 'h04, 'h123, 0, 'h123);
    step(JUMP, 0, 0, 1, 'h00F, 0, 'h00F);
    step(JUMP, 2, 1, 'h04, 'h123, 0, 'h010);
    step(JUMP, 0, 0, 1, 'h00A, 0, 'h00A);
    step(CALL, 0, 1, 0, 'h101, 0, 'h101);
    step(CALL, 0, 1, 0, 'h201, 0, 'h201);
    step(CALL, 0, 1, 0, 'h301, 0, 'h301);
    step(CALL, 0, 1, 0, 'h401, 0, 'h401);
    chk("full_after4", int'(bus.stack_full), 1);
    chk("err_after4", int'(bus.stack_err), 0);
    step(CALL, 0, 1, 0, 'h500, 0, 'h500);
    chk("err_overflow", int'(bus.stack_err), 1);
    step(RET, 0, 1, 0, 0, 0, 'h302);
    step(RET, 0, 1, 0, 0, 0, 'h202);
    step(RET, 0, 1, 0, 0, 0, 'h102);
    step(RET, 0, 1, 0, 0, 0, 'h00B);
    step(RET, 0, 1, 0, 0, 0, 'h00C);
    chk("err_underflow", int'(bus.stack_err), 1);
    step(JUMP, 0, 0, 1, 'h060, 0, 'h060);
    for (int i = 0; i < 5; i++) step(WAIT, 3, 0, 'hF7, 0, 0, 'h060);
    step(WAIT, 3, 0, 'h08, 0, 0, 'h061);
    rst = 1'b1;
    step(WAIT, 3, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(CONT, 0, 0, 0, 0, 0, 1);
    step(JMAP, 0, 0, 0, 'h111, 'h3F0, 'h3F0);
    step(JUMP, 0, 0, 1, 'h7FF, 0, 'h7FF);
    step(CONT, 0, 0, 0, 0, 0, 'h000);
    step(JUMP, 0, 0, 1, 'h020, 0, 'h020);
    step(LDCT, 0, 0, 0, 3, 0, 'h021);
    for (int i = 0; i < 4; i++)
      step(RPCT, 0, 0, 0, 'h050, 0, EN ? (i < 3 ? 'h050 : 'h051) : 'h022 + i);
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 40) == 0;
      step($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 255),
           $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1), -1);
    end
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
